// File: rtl/dmem_arb_pkg.sv
// Shared types for the DMEM arbiter: FSM state, read owner and statistics width.
package dmem_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_e;
  typedef enum logic {OWN_CORE, OWN_HOST} arb_owner_e;

  localparam int STAT_W = 32;

endpackage

// File: rtl/dmem_arb_sat_ctr.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module dmem_arb_sat_ctr
  import dmem_arb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  output logic [STAT_W-1:0] count_o
);

  logic [STAT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port DMEM arbiter between core (priority) and host (anti-starvation).
// Define DMEM_ARB_STATS_EN to enable the stall/wait statistics counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  core_req_i,
  input  logic                  core_we_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  input  logic [DATA_WIDTH-1:0] core_wdata_i,
  output logic                  core_stall_o,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [DATA_WIDTH-1:0] host_wdata_i,
  output logic                  host_gnt_o,
  output logic                  host_rvalid_o,
  output logic [DATA_WIDTH-1:0] host_rdata_o,
  output logic                  dmem_en_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_address_o,
  output logic [DATA_WIDTH-1:0] dmem_dataIn_o,
  input  logic [DATA_WIDTH-1:0] dmem_dataOut_i,
  output logic [31:0]           stat_core_stall_o,
  output logic [31:0]           stat_host_wait_o
);

  localparam int LAT_W = $clog2(MEM_LATENCY + 1);
  localparam int STV_W = $clog2(STARVE_LIMIT + 1);

  arb_state_e            state_q, state_d;
  arb_owner_e            owner_q, owner_d;
  logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_d;
  logic [STV_W-1:0]      starve_q, starve_d;
  logic [DATA_WIDTH-1:0] core_hold_q, core_hold_d;
  logic [DATA_WIDTH-1:0] host_hold_q, host_hold_d;

  logic host_wins, core_issue, host_issue, read_ret;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CORE;
      lat_cnt_q   <= '0;
      starve_q    <= '0;
      core_hold_q <= '0;
      host_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      starve_q    <= starve_d;
      core_hold_q <= core_hold_d;
      host_hold_q <= host_hold_d;
    end
  end

  // The host only overtakes a requesting core once the starvation count is full.
  assign host_wins = host_req_i && (!core_req_i || (starve_q == STV_W'(STARVE_LIMIT)));

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lat_cnt_d   = lat_cnt_q;
    starve_d    = starve_q;
    core_hold_d = core_hold_q;
    host_hold_d = host_hold_q;
    core_issue  = 1'b0;
    host_issue  = 1'b0;
    read_ret    = 1'b0;

    case (state_q)
      IDLE: begin
        host_issue = host_wins;
        core_issue = core_req_i && !host_wins;
        if ((core_issue && !core_we_i) || (host_issue && !host_we_i)) begin
          state_d   = BUSY;
          lat_cnt_d = LAT_W'(MEM_LATENCY);
          owner_d   = host_issue ? OWN_HOST : OWN_CORE;
        end
      end
      BUSY: begin
        lat_cnt_d = lat_cnt_q - 1'b1;
        if (lat_cnt_q == LAT_W'(1)) begin
          read_ret = 1'b1;
          state_d  = IDLE;
          if (owner_q == OWN_HOST) host_hold_d = dmem_dataOut_i;
          else                     core_hold_d = dmem_dataOut_i;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!host_req_i || host_issue) starve_d = '0;
    else if (core_issue && (starve_q != STV_W'(STARVE_LIMIT))) starve_d = starve_q + 1'b1;
  end

  assign dmem_en_o      = core_issue || host_issue;
  assign dmem_we_o      = host_issue ? host_we_i : (core_issue && core_we_i);
  assign dmem_address_o = host_issue ? host_addr_i : core_addr_i;
  assign dmem_dataIn_o  = host_issue ? host_wdata_i : core_wdata_i;

  assign core_rvalid_o = read_ret && (owner_q == OWN_CORE);
  assign host_rvalid_o = read_ret && (owner_q == OWN_HOST);
  assign core_rdata_o  = core_rvalid_o ? dmem_dataOut_i : core_hold_q;
  assign host_rdata_o  = host_rvalid_o ? dmem_dataOut_i : host_hold_q;
  assign host_gnt_o    = host_issue;
  assign core_stall_o  = core_req_i && !((core_issue && core_we_i) || core_rvalid_o);

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_sat_ctr u_stat_core_stall (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (core_stall_o),
    .count_o (stat_core_stall_o)
  );

  dmem_arb_sat_ctr u_stat_host_wait (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .en_i    (host_req_i && !host_gnt_o),
    .count_o (stat_host_wait_o)
  );
`else
  assign stat_core_stall_o = '0;
  assign stat_host_wait_o  = '0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level reference model.
module tb_dmem_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int LAT   = 2;
  localparam int LIMIT = 8;
`ifdef DMEM_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          coreReq = 1'b0, coreWe = 1'b0, hostReq = 1'b0, hostWe = 1'b0;
  logic [AW-1:0] coreAddr = '0, hostAddr = '0;
  logic [DW-1:0] coreWdata = '0, hostWdata = '0, dmemDataOut = '0;
  logic          coreStall, coreRvalid, hostGnt, hostRvalid, dmemEn, dmemWe;
  logic [DW-1:0] coreRdata, hostRdata, dmemDataIn;
  logic [AW-1:0] dmemAddress;
  logic [31:0]   statCoreStall, statHostWait;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_WIDTH   (AW),
    .DATA_WIDTH   (DW),
    .MEM_LATENCY  (LAT),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk_i             (clk),
    .rst_ni            (rstN),
    .core_req_i        (coreReq),
    .core_we_i         (coreWe),
    .core_addr_i       (coreAddr),
    .core_wdata_i      (coreWdata),
    .core_stall_o      (coreStall),
    .core_rvalid_o     (coreRvalid),
    .core_rdata_o      (coreRdata),
    .host_req_i        (hostReq),
    .host_we_i         (hostWe),
    .host_addr_i       (hostAddr),
    .host_wdata_i      (hostWdata),
    .host_gnt_o        (hostGnt),
    .host_rvalid_o     (hostRvalid),
    .host_rdata_o      (hostRdata),
    .dmem_en_o         (dmemEn),
    .dmem_we_o         (dmemWe),
    .dmem_address_o    (dmemAddress),
    .dmem_dataIn_o     (dmemDataIn),
    .dmem_dataOut_i    (dmemDataOut),
    .stat_core_stall_o (statCoreStall),
    .stat_host_wait_o  (statHostWait)
  );

  // Reference model: the memory contents, the read in flight and the fairness count.
  logic [DW-1:0] mem [0:31];
  int            mBusy = 0;
  bit            mOwnerHost = 0;
  int            mStarve = 0;
  logic [DW-1:0] mCoreHold = '0, mHostHold = '0, mRetData = '0;
  int unsigned   mStatStall = 0, mStatWait = 0;
  bit            coreDone = 0, hostDone = 0;
  int            mode = 2;
  int            numCompared = 0, numMismatched = 0;
  int            gntSeen = 0, rstCycles = 0;

  function automatic int memIdx(input logic [AW-1:0] a);
    return int'(a[7:3]);
  endfunction

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    numCompared++;
    if (obs !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, obs, exp);
    end
  endtask

  // Memory read data is only meaningful in the model's return cycle; otherwise garbage.
  task automatic advance();
    @(posedge clk);
    #1;
    dmemDataOut = (mBusy == 1) ? mRetData : {$urandom, $urandom};
  endtask

  task automatic stepModel();
    bit            hostIssue, coreIssue, ret, expCRv, expHRv, expStall, expEn, expWe;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expWdata;
    @(negedge clk);
    coreDone = 0;
    hostDone = 0;
    if (!rstN) begin
      mBusy = 0; mStarve = 0; mCoreHold = '0; mHostHold = '0;
      mStatStall = 0; mStatWait = 0;
    end
    checkOutput("stat_core_stall", statCoreStall, STATS ? mStatStall : 0);
    checkOutput("stat_host_wait", statHostWait, STATS ? mStatWait : 0);

    hostIssue = 0; coreIssue = 0; ret = 0; expCRv = 0; expHRv = 0;
    if (mBusy == 0) begin
      hostIssue = hostReq && (!coreReq || mStarve == LIMIT);
      coreIssue = coreReq && !hostIssue;
    end else begin
      ret    = (mBusy == 1);
      expCRv = ret && !mOwnerHost;
      expHRv = ret && mOwnerHost;
    end
    expEn    = coreIssue || hostIssue;
    expWe    = hostIssue ? hostWe : coreWe;
    expAddr  = hostIssue ? hostAddr : coreAddr;
    expWdata = hostIssue ? hostWdata : coreWdata;
    expStall = coreReq && !((coreIssue && coreWe) || expCRv);

    checkOutput("core_stall", coreStall, expStall);
    checkOutput("core_rvalid", coreRvalid, expCRv);
    checkOutput("core_rdata", coreRdata, expCRv ? mRetData : mCoreHold);
    checkOutput("host_gnt", hostGnt, hostIssue);
    checkOutput("host_rvalid", hostRvalid, expHRv);
    checkOutput("host_rdata", hostRdata, expHRv ? mRetData : mHostHold);
    checkOutput("dmem_en", dmemEn, expEn);
    if (expEn) begin
      checkOutput("dmem_we", dmemWe, expWe);
      checkOutput("dmem_address", dmemAddress, expAddr);
      if (expWe) checkOutput("dmem_dataIn", dmemDataIn, expWdata);
    end

    if (rstN) begin
      if (mBusy > 0) begin
        if (ret) begin
          if (mOwnerHost) mHostHold = mRetData;
          else            mCoreHold = mRetData;
        end
        mBusy--;
      end else if (expEn) begin
        if (expWe) mem[memIdx(expAddr)] = expWdata;
        else begin
          mRetData   = mem[memIdx(expAddr)];
          mBusy      = LAT;
          mOwnerHost = hostIssue;
        end
      end
      if (!hostReq || hostIssue) mStarve = 0;
      else if (coreIssue && mStarve < LIMIT) mStarve++;
      coreDone = (coreIssue && coreWe) || expCRv;
      hostDone = hostIssue;
      if (expStall) mStatStall++;
      if (hostReq && !hostIssue) mStatWait++;
    end
  endtask

  // mode 0: random traffic; mode 1: both sides stream writes back to back.
  task automatic applyStimulus();
    if (!coreReq || coreDone) begin
      coreReq   = (mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
      coreWe    = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      coreAddr  = AW'($urandom_range(0, 255));
      coreWdata = {$urandom, $urandom};
    end
    if (!hostReq || hostDone) begin
      hostReq   = (mode == 1) ? 1'b1 : ($urandom_range(0, 1) != 0);
      hostWe    = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      hostAddr  = AW'($urandom_range(0, 255));
      hostWdata = {$urandom, $urandom};
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    $display("[TB] starting, stats build = %0d", STATS);

    stepModel();
    stepModel();
    advance(); rstN = 1'b1; stepModel();

    // Core write 0xA5 to 0x10 completes in its issue cycle.
    advance(); coreReq = 1; coreWe = 1; coreAddr = 32'h10; coreWdata = 64'hA5;
    stepModel();
    checkOutput("t1_dmem_we", dmemWe, 1'b1);
    checkOutput("t1_no_stall", coreStall, 1'b0);

    // Core read of 0x10 stalls for LAT cycles and then returns 0xA5.
    advance(); coreWe = 0; stepModel();
    advance(); stepModel();
    advance(); stepModel();
    checkOutput("t2_rvalid", coreRvalid, 1'b1);
    checkOutput("t2_rdata", coreRdata, 64'hA5);
    advance(); coreReq = 0; stepModel();
    checkOutput("t6_stat_core_stall", statCoreStall, STATS ? 64'd2 : 64'd0);

    // Host read of 0x20 alongside a core write; the core hold register must not move.
    advance(); coreReq = 1; coreWe = 1; coreAddr = 32'h30; coreWdata = 64'h77;
    hostReq = 1; hostWe = 0; hostAddr = 32'h20;
    stepModel();
    advance(); coreReq = 0; stepModel();
    checkOutput("t4_host_gnt", hostGnt, 1'b1);
    advance(); hostReq = 0; stepModel();
    advance(); stepModel();
    checkOutput("t4_host_rvalid", hostRvalid, 1'b1);
    checkOutput("t4_core_hold", coreRdata, 64'hA5);

    // Reset lands while a core read is in flight; the read is retried afterwards.
    advance(); coreReq = 1; coreWe = 0; coreAddr = 32'h30; stepModel();
    advance(); rstN = 0; stepModel();
    checkOutput("t5_core_rdata_cleared", coreRdata, 64'h0);
    advance(); stepModel();
    checkOutput("t5_no_rvalid", coreRvalid, 1'b0);
    advance(); rstN = 1; stepModel();
    checkOutput("t5_reissue", dmemEn, 1'b1);
    advance(); stepModel();
    advance(); stepModel();
    checkOutput("t5_rdata", coreRdata, 64'h77);
    advance(); coreReq = 0; stepModel();

    // Both sides streaming writes: host gets one slot after every LIMIT core issues.
    mode = 1;
    gntSeen = 0;
    repeat (2 * (LIMIT + 1)) begin
      advance(); applyStimulus(); stepModel();
      gntSeen += int'(hostGnt);
    end
    checkOutput("t3_host_gnts", gntSeen, 64'd2);

    mode = 0;
    repeat (4000) begin
      advance();
      if (!rstN) begin
        rstCycles++;
        if (rstCycles >= 2) rstN = 1;
      end else if (mBusy > 0 && $urandom_range(0, 39) == 0) begin
        rstN = 0;
        rstCycles = 0;
      end
      applyStimulus();
      stepModel();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
